// File: rtl/coriolis_fpmul_rr_arbiter_if.sv
// rtl/coriolis_fpmul_rr_arbiter_if.sv - requester, multiplier and result bus between kernel leaves and the shared FP multiplier
//
// Signal groups:
//   requester side : req_valid/req_ready/req_x/req_y (NREQ lanes, operands packed lane i at [i*STREAMW +: STREAMW])
//   multiplier side: mul_x/mul_y/mul_stall out to the multiplier, mul_r back
//   result side    : out1_s0 common data bus, ovalid one-hot destination, oready per requester
//   status         : busy
// Modports: slave = arbiter view, master = environment (requesters + multiplier) view.
interface coriolis_fpmul_rr_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int STREAMW = 34
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*STREAMW-1:0] req_x;
    logic [NREQ*STREAMW-1:0] req_y;
    logic [STREAMW-1:0]      mul_x;
    logic [STREAMW-1:0]      mul_y;
    logic                    mul_stall;
    logic [STREAMW-1:0]      mul_r;
    logic [STREAMW-1:0]      out1_s0;
    logic [NREQ-1:0]         ovalid;
    logic [NREQ-1:0]         oready;
    logic                    busy;

    modport slave (
        input  req_valid, req_x, req_y, mul_r, oready,
        output req_ready, mul_x, mul_y, mul_stall, out1_s0, ovalid, busy
    );

    modport master (
        output req_valid, req_x, req_y, mul_r, oready,
        input  req_ready, mul_x, mul_y, mul_stall, out1_s0, ovalid, busy
    );
endinterface

// File: rtl/coriolis_fpmul_rr_arbiter.sv
// rtl/coriolis_fpmul_rr_arbiter.sv - round-robin sharing of one pipelined FloPoCo FP multiplier among NREQ requesters
//
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   bus  : coriolis_fpmul_rr_arbiter_if.slave
//          req_valid/req_ready/req_x/req_y  requester operand streams
//          mul_x/mul_y/mul_stall/mul_r      shared multiplier (latency LAT)
//          out1_s0/ovalid/oready            registered result, one-hot destination
//          busy                             any tag in flight or result held
//
// A shadow pipeline of {v, id} tags, LAT deep, tracks each operation through
// the multiplier so the result can be steered back to its requester. Tag pipe,
// multiplier and output register all freeze together while the held result
// is not accepted, so results leave strictly in acceptance order.
module coriolis_fpmul_rr_arbiter #(
    parameter int              STREAMW   = 34,
    parameter int              NREQ      = 4,
    parameter int              IDW       = 2,
    parameter int              LAT       = 3,
    parameter bit              USE_CONST = 1'b0,
    parameter logic [STREAMW-1:0] CONST_Y = 34'h1bd80ae10
) (
    input logic                        clk,
    input logic                        rst,
    coriolis_fpmul_rr_arbiter_if.slave bus
);

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;

    tag_t               tag_q [LAT];
    logic               out_vld;
    logic [IDW-1:0]     out_id;
    logic [STREAMW-1:0] out_data;
    logic [IDW-1:0]     rr_ptr;

    logic               stall;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_id;
    logic               grant_any;
    logic [STREAMW-1:0] mul_x_c;
    logic [STREAMW-1:0] mul_y_c;
    logic [NREQ-1:0]    ovalid_c;
    logic               tags_busy;

    // The only thing that can stop the pipe is a held result nobody takes.
    assign stall = out_vld & ~bus.oready[out_id];

    // Round-robin search starting just after the last accepted requester.
    // Grant is only ever raised on a valid lane, so grant == accept.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        if (!stall) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!grant_any && bus.req_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        mul_x_c = '0;
        mul_y_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mul_x_c = bus.req_x[i*STREAMW +: STREAMW];
                mul_y_c = USE_CONST ? CONST_Y : bus.req_y[i*STREAMW +: STREAMW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= IDW'(NREQ - 1);
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
            out_vld  <= 1'b0;
            out_id   <= '0;
            out_data <= '0;
        end else if (!stall) begin
            if (grant_any) begin
                rr_ptr <= grant_id;
            end
            tag_q[0] <= {grant_any, grant_id};
            for (int s = 1; s < LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            out_vld <= tag_q[LAT-1].v;
            out_id  <= tag_q[LAT-1].id;
            // Bubbles leave the last result on the bus untouched.
            if (tag_q[LAT-1].v) begin
                out_data <= bus.mul_r;
            end
        end
    end

    always_comb begin
        ovalid_c = '0;
        if (out_vld) begin
            ovalid_c[out_id] = 1'b1;
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            tags_busy = tags_busy | tag_q[s].v;
        end
    end

    assign bus.req_ready = grant;
    assign bus.mul_x     = mul_x_c;
    assign bus.mul_y     = mul_y_c;
    assign bus.mul_stall = stall;
    assign bus.out1_s0   = out_data;
    assign bus.ovalid    = ovalid_c;
    assign bus.busy      = tags_busy | out_vld;

endmodule

// File: tb/tb_coriolis_fpmul_rr_arbiter.sv
// tb/tb_coriolis_fpmul_rr_arbiter.sv - self-checking bench for coriolis_fpmul_rr_arbiter
module tb_coriolis_fpmul_rr_arbiter;
    localparam int NREQ = 4;
    localparam int STREAMW = 34;
    localparam int IDW = 2;
    localparam int LAT = 3;
    localparam logic [33:0] CONST_Y = 34'h1bd80ae10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coriolis_fpmul_rr_arbiter_if #(.NREQ(NREQ), .STREAMW(STREAMW)) bus ();
    coriolis_fpmul_rr_arbiter_if #(.NREQ(NREQ), .STREAMW(STREAMW)) bus_c ();

    coriolis_fpmul_rr_arbiter #(
        .STREAMW(STREAMW), .NREQ(NREQ), .IDW(IDW), .LAT(LAT), .USE_CONST(1'b0), .CONST_Y(CONST_Y)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    coriolis_fpmul_rr_arbiter #(
        .STREAMW(STREAMW), .NREQ(NREQ), .IDW(IDW), .LAT(LAT), .USE_CONST(1'b1), .CONST_Y(CONST_Y)
    ) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c)
    );

    // Reference FP multiply: normal operands only, truncated mantissa.
    function automatic logic [33:0] fpmul(input logic [33:0] a, input logic [33:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic [22:0] f;
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 10'd1;
        end else begin
            f = m[45:23];
        end
        return {2'b01, a[31] ^ b[31], e[7:0], f};
    endfunction

    // Multiplier model: LAT stages, frozen by mul_stall.
    logic [33:0] mp [LAT];
    always @(posedge clk) begin
        if (!bus.mul_stall) begin
            mp[0] <= fpmul(bus.mul_x, bus.mul_y);
            for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
        end
    end
    assign bus.mul_r   = mp[LAT-1];
    assign bus_c.mul_r = '0;

    int passed = 0;
    int total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_op(input int j, input logic [33:0] x, input logic [33:0] y);
        bus.req_x[j*STREAMW +: STREAMW] = x;
        bus.req_y[j*STREAMW +: STREAMW] = y;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.oready = '1;
        bus_c.req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;

    typedef struct {
        int          id;
        logic [33:0] d;
    } exp_t;

    vec_t vt [16];
    exp_t sbq [$];

    // Compare a consumed result against the head of the scoreboard.
    task automatic consume_check();
        logic [3:0] taken;
        exp_t       e;
        int         gid;
        taken = bus.ovalid & bus.oready;
        if (taken != 4'b0) begin
            gid = 0;
            for (int j = 0; j < NREQ; j++) if (bus.ovalid[j]) gid = j;
            if (sbq.size() == 0) begin
                check("rand_unexpected_result", 64'(gid), 64'hffff);
            end else begin
                e = sbq.pop_front();
                check("rand_result_id", 64'(gid), 64'(e.id));
                check("rand_result_data", 64'(bus.out1_s0), 64'(e.d));
            end
        end
    endtask

    initial begin
        logic [33:0] exp_x;
        logic [33:0] x;
        logic [33:0] y;
        logic        stale;

        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.oready = '1;
        bus_c.req_valid = '0;
        bus_c.req_x = '0;
        bus_c.req_y = '0;
        bus_c.oready = '1;

        vt[0]  = '{4'b1111, 4'b0001};
        vt[1]  = '{4'b1111, 4'b0010};
        vt[2]  = '{4'b1111, 4'b0100};
        vt[3]  = '{4'b1111, 4'b1000};
        vt[4]  = '{4'b1111, 4'b0001};
        vt[5]  = '{4'b1111, 4'b0010};
        vt[6]  = '{4'b1111, 4'b0100};
        vt[7]  = '{4'b1111, 4'b1000};
        vt[8]  = '{4'b0000, 4'b0000};
        vt[9]  = '{4'b0110, 4'b0010};
        vt[10] = '{4'b0110, 4'b0100};
        vt[11] = '{4'b0110, 4'b0010};
        vt[12] = '{4'b1001, 4'b1000};
        vt[13] = '{4'b1001, 4'b0001};
        vt[14] = '{4'b1000, 4'b1000};
        vt[15] = '{4'b1000, 4'b1000};

        // Reset state
        do_reset();
        #1;
        check("reset_ovalid", 64'(bus.ovalid), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        check("reset_out1_s0", 64'(bus.out1_s0), 64'h0);
        check("reset_stall", 64'(bus.mul_stall), 64'h0);

        // Round-robin table
        for (int j = 0; j < NREQ; j++) set_op(j, {2'b01, 32'h3f800000 + 32'(j)}, {2'b01, 32'h40000000 + 32'(j)});
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.req_valid = vt[i].valid;
            #1;
            exp_x = '0;
            for (int j = 0; j < NREQ; j++) if (vt[i].exp_ready[j]) exp_x = {2'b01, 32'h3f800000 + 32'(j)};
            check($sformatf("rr_ready[%0d]", i), 64'(bus.req_ready), 64'(vt[i].exp_ready));
            check($sformatf("rr_mul_x[%0d]", i), 64'(bus.mul_x), 64'(exp_x));
        end
        @(negedge clk);
        bus.req_valid = '0;

        // Latency and data: req2 only, 1.0 * 2.0
        do_reset();
        set_op(2, 34'h13f800000, 34'h140000000);
        bus.req_valid = 4'b0100;
        #1;
        check("lat_grant", 64'(bus.req_ready), 64'h4);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            check($sformatf("lat_ovalid_edge%0d", k), 64'(bus.ovalid), (k == 4) ? 64'h4 : 64'h0);
            if (k == 4) check("lat_out1_s0", 64'(bus.out1_s0), 64'h140000000);
        end

        // Stall: result for req1 held with oready[1]=0
        do_reset();
        bus.oready = 4'b1101;
        set_op(1, 34'h13fc00000, 34'h140000000);
        bus.req_valid = 4'b0010;
        #1;
        check("stall_grant1", 64'(bus.req_ready), 64'h2);
        @(negedge clk);
        set_op(0, 34'h140000000, 34'h140400000);
        bus.req_valid = 4'b0001;
        #1;
        check("stall_grant0a", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        set_op(0, 34'h13f000000, 34'h140800000);
        #1;
        check("stall_grant0b", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("stall_pre_ovalid", 64'(bus.ovalid), 64'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req_valid = 4'b1111;
            #1;
            check($sformatf("stall_mul_stall[%0d]", c), 64'(bus.mul_stall), 64'h1);
            check($sformatf("stall_req_ready[%0d]", c), 64'(bus.req_ready), 64'h0);
            check($sformatf("stall_ovalid[%0d]", c), 64'(bus.ovalid), 64'h2);
            check($sformatf("stall_out1_s0[%0d]", c), 64'(bus.out1_s0), 64'h140400000);
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.oready = 4'b1111;
        #1;
        check("stall_release", 64'(bus.mul_stall), 64'h0);
        check("stall_release_ovalid", 64'(bus.ovalid), 64'h2);
        @(negedge clk);
        #1;
        check("stall_after1_ovalid", 64'(bus.ovalid), 64'h1);
        check("stall_after1_data", 64'(bus.out1_s0), 64'h140c00000);
        @(negedge clk);
        #1;
        check("stall_after2_ovalid", 64'(bus.ovalid), 64'h1);
        check("stall_after2_data", 64'(bus.out1_s0), 64'h140000000);
        @(negedge clk);
        #1;
        check("stall_drained_ovalid", 64'(bus.ovalid), 64'h0);
        check("stall_drained_busy", 64'(bus.busy), 64'h0);

        // Reset with three operations in flight
        do_reset();
        bus.req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("rst_busy_before", 64'(bus.busy), 64'h1);
        rst = 1'b1;
        #1;
        check("rst_ovalid_async", 64'(bus.ovalid), 64'h0);
        check("rst_busy_async", 64'(bus.busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (bus.ovalid != 4'b0) stale = 1'b1;
        end
        check("rst_no_stale_ovalid", 64'(stale), 64'h0);
        bus.req_valid = 4'b1111;
        #1;
        check("rst_next_grant", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = '0;

        // Constant Y instance
        do_reset();
        for (int j = 0; j < NREQ; j++) begin
            bus_c.req_x[j*STREAMW +: STREAMW] = {2'b01, 32'h3f800000};
            bus_c.req_y[j*STREAMW +: STREAMW] = {2'b10, 32'hdeadbee0 + 32'(j)};
        end
        bus_c.oready = '1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            bus_c.req_valid = 4'b1111;
            #1;
            check($sformatf("const_grant[%0d]", c), 64'(bus_c.req_ready), 64'(4'b0001 << c));
            check($sformatf("const_mul_y[%0d]", c), 64'(bus_c.mul_y), 64'(CONST_Y));
        end
        @(negedge clk);
        bus_c.req_valid = '0;
        #1;
        check("const_idle_mul_y", 64'(bus_c.mul_y), 64'h0);

        // Random traffic with in-order scoreboard
        do_reset();
        sbq.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int j = 0; j < NREQ; j++) begin
                bus.oready[j] = ($urandom_range(0, 3) != 0);
                x = {2'b01, 1'b0, 8'($urandom_range(110, 140)), 23'($urandom())};
                y = {2'b01, 1'b0, 8'($urandom_range(110, 140)), 23'($urandom())};
                set_op(j, x, y);
            end
            #1;
            check("rand_ovalid_onehot0", 64'($onehot0(bus.ovalid)), 64'h1);
            check("rand_ready_legal", 64'($onehot0(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == 4'b0)), 64'h1);
            for (int j = 0; j < NREQ; j++) begin
                if (bus.req_ready[j] && bus.req_valid[j])
                    sbq.push_back('{j, fpmul(bus.req_x[j*STREAMW +: STREAMW], bus.req_y[j*STREAMW +: STREAMW])});
            end
            consume_check();
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.oready = '1;
        for (int c = 0; c < 20; c++) begin
            #1;
            consume_check();
            @(negedge clk);
        end
        check("rand_scoreboard_empty", 64'(sbq.size()), 64'h0);
        check("rand_final_busy", 64'(bus.busy), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
